// File: rtl/vga_pkg.sv
// Shared VGA timing sets and sizing helpers for the timing generator and its users.
package vga_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } timing_t;

  localparam timing_t VGA640_H  = '{active: 640, fp: 16, sync: 96,  bp: 48};
  localparam timing_t VGA640_V  = '{active: 480, fp: 10, sync: 2,   bp: 33};
  localparam timing_t SVGA800_H = '{active: 800, fp: 56, sync: 120, bp: 64};
  localparam timing_t SVGA800_V = '{active: 600, fp: 37, sync: 6,   bp: 23};

  function automatic int unsigned timing_total(timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

  // Width of a packed {R,G,B} word for a given per-channel width.
  function automatic int unsigned rgb_width(int unsigned color_w);
    return 3 * color_w;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Resettable, enable-gated shift register; DEPTH=0 collapses to a wire.
module vga_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    assign q = d;
    logic unused;
    assign unused = ^{clk, rst, en};
  end else begin : g_sr
    logic [DEPTH-1:0][WIDTH-1:0] sr;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sr <= '0;
      end else if (en) begin
        sr[0] <= d;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          sr[i] <= sr[i-1];
        end
      end
    end

    assign q = sr[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA scanner: fetch coordinates plus sync/blank/RGB delayed to match
// the pixel source latency.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA640_H.active,
  parameter int unsigned H_FP     = VGA640_H.fp,
  parameter int unsigned H_SYNC   = VGA640_H.sync,
  parameter int unsigned H_BP     = VGA640_H.bp,
  parameter int unsigned V_ACTIVE = VGA640_V.active,
  parameter int unsigned V_FP     = VGA640_V.fp,
  parameter int unsigned V_SYNC   = VGA640_V.sync,
  parameter int unsigned V_BP     = VGA640_V.bp,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned COLOR_W  = 3,
  parameter int unsigned PIPE     = 2,
  parameter int unsigned CNT_W    = 11
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [rgb_width(COLOR_W)-1:0]   pix_in,
  output logic [CNT_W-1:0]                col,
  output logic [CNT_W-1:0]                row,
  output logic                            fetch_de,
  output logic [COLOR_W-1:0]              R,
  output logic [COLOR_W-1:0]              G,
  output logic [COLOR_W-1:0]              B,
  output logic                            Hs,
  output logic                            Vs,
  output logic                            de,
  output logic                            frame_start,
  output logic                            vblank
);

  localparam int unsigned H_TOTAL = timing_total(timing_t'{H_ACTIVE, H_FP, H_SYNC, H_BP});
  localparam int unsigned V_TOTAL = timing_total(timing_t'{V_ACTIVE, V_FP, V_SYNC, V_BP});
  localparam int unsigned PIX_W   = rgb_width(COLOR_W);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      COLOR_W == 0 || CNT_W == 0 || PIPE > 4 ||
      (64'(1) << CNT_W) <= 64'(H_TOTAL) || (64'(1) << CNT_W) <= 64'(V_TOTAL)) begin : g_bad_params
    $error("vga_timing_gen: illegal timing parameters");
  end

  logic hs_raw;
  logic vs_raw;
  logic hs_dly;
  logic vs_dly;
  logic de_dly;

  // Raster counters: col runs fastest, row advances on each line wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (col == H_LAST) begin
        col <= '0;
        row <= (row == V_LAST) ? '0 : row + CNT_W'(1);
      end else begin
        col <= col + CNT_W'(1);
      end
    end
  end

  assign fetch_de    = (col < H_ACT_C) && (row < V_ACT_C);
  assign vblank      = (row >= V_ACT_C);
  assign frame_start = rst && en && (col == '0) && (row == '0);

  assign hs_raw = (col >= HS_START) && (col < HS_END);
  assign vs_raw = (row >= VS_START) && (row < VS_END);

  vga_delay_line #(
    .WIDTH (3),
    .DEPTH (PIPE)
  ) u_ctl_dly (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .d   ({hs_raw, vs_raw, fetch_de}),
    .q   ({hs_dly, vs_dly, de_dly})
  );

  // Output register lines sync/blank up with pixel data from the source.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      R  <= '0;
      G  <= '0;
      B  <= '0;
      de <= 1'b0;
      Hs <= ~HS_POL;
      Vs <= ~VS_POL;
    end else if (en) begin
      de        <= de_dly;
      Hs        <= hs_dly ? HS_POL : ~HS_POL;
      Vs        <= vs_dly ? VS_POL : ~VS_POL;
      {R, G, B} <= de_dly ? pix_in : PIX_W'(0);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: hand-derived raster vectors, an async-reset sequence and a
// randomised-enable run checked against a position-from-step-count reference model.
module tb_vga_timing_gen;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, pipe, cw;
    bit hpol, vpol;
  } cfg_t;

  typedef struct {
    int col, row, rgb;
    bit fde, vb, fs, hs, vs, de;
  } exp_t;

  typedef struct {
    int n, col, row;
    bit hs, vs, de, fs, vb;
  } vec_t;

  localparam cfg_t CA = '{8, 2, 3, 3, 4, 1, 2, 1, 2, 3, 1'b0, 1'b0};
  localparam cfg_t CB = '{5, 1, 2, 2, 3, 1, 1, 2, 0, 2, 1'b1, 1'b1};
  localparam cfg_t CC = '{800, 56, 120, 64, 600, 37, 6, 23, 1, 4, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;

  logic [8:0]  a_pix;
  logic [4:0]  a_col, a_row;
  logic [2:0]  a_r, a_g, a_b;
  logic        a_fde, a_hs, a_vs, a_de, a_fs, a_vb;

  logic [5:0]  b_pix;
  logic [3:0]  b_col, b_row;
  logic [1:0]  b_r, b_g, b_b;
  logic        b_fde, b_hs, b_vs, b_de, b_fs, b_vb;

  logic [11:0] c_pix;
  logic [10:0] c_col, c_row;
  logic [3:0]  c_r, c_g, c_b;
  logic        c_fde, c_hs, c_vs, c_de, c_fs, c_vb;

  int checks   = 0;
  int failures = 0;
  int n        = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(3), .PIPE(2), .CNT_W(5)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en), .pix_in(a_pix), .col(a_col), .row(a_row),
    .fetch_de(a_fde), .R(a_r), .G(a_g), .B(a_b), .Hs(a_hs), .Vs(a_vs), .de(a_de),
    .frame_start(a_fs), .vblank(a_vb)
  );

  vga_timing_gen #(
    .H_ACTIVE(5), .H_FP(1), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(2), .PIPE(0), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en), .pix_in(b_pix), .col(b_col), .row(b_row),
    .fetch_de(b_fde), .R(b_r), .G(b_g), .B(b_b), .Hs(b_hs), .Vs(b_vs), .de(b_de),
    .frame_start(b_fs), .vblank(b_vb)
  );

  vga_timing_gen #(
    .H_ACTIVE(800), .H_FP(56), .H_SYNC(120), .H_BP(64),
    .V_ACTIVE(600), .V_FP(37), .V_SYNC(6), .V_BP(23),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(4), .PIPE(1), .CNT_W(11)
  ) dut_c (
    .clk(clk), .rst(rst), .en(en), .pix_in(c_pix), .col(c_col), .row(c_row),
    .fetch_de(c_fde), .R(c_r), .G(c_g), .B(c_b), .Hs(c_hs), .Vs(c_vs), .de(c_de),
    .frame_start(c_fs), .vblank(c_vb)
  );

  function automatic int pix_data(cfg_t c, int pc, int pr);
    return (pc * 5 + pr * 3 + 1) & ((1 << (3 * c.cw)) - 1);
  endfunction

  // Pixel the source presents during enabled step m: data for the position PIPE steps back.
  function automatic int src_pix(cfg_t c, int m);
    int ht, vt, k;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    if (m < c.pipe) return int'($urandom);
    k = m - c.pipe;
    return pix_data(c, k % ht, (k / ht) % vt);
  endfunction

  // Everything follows from n, the number of enabled edges since reset.
  function automatic exp_t model(cfg_t c, int steps, bit en_now);
    exp_t e;
    int ht, vt, m, pc, pr;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    e.col = steps % ht;
    e.row = (steps / ht) % vt;
    e.fde = (e.col < c.ha) && (e.row < c.va);
    e.vb  = (e.row >= c.va);
    e.fs  = en_now && (e.col == 0) && (e.row == 0);
    e.hs  = ~c.hpol;
    e.vs  = ~c.vpol;
    e.de  = 1'b0;
    e.rgb = 0;
    if (steps >= c.pipe + 1) begin
      m  = steps - c.pipe - 1;
      pc = m % ht;
      pr = (m / ht) % vt;
      if (pc >= c.ha + c.hf && pc < c.ha + c.hf + c.hs) e.hs = c.hpol;
      if (pr >= c.va + c.vf && pr < c.va + c.vf + c.vs) e.vs = c.vpol;
      e.de = (pc < c.ha) && (pr < c.va);
      if (e.de) e.rgb = pix_data(c, pc, pr);
    end
    return e;
  endfunction

  task automatic chk(string nm, integer act, integer req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (n=%0d t=%0t)", nm, act, req, n, $time);
    end
  endtask

  task automatic check_all();
    exp_t e;
    e = model(CA, n, en && rst);
    chk("a.col", a_col, e.col);  chk("a.row", a_row, e.row);
    chk("a.fetch_de", a_fde, e.fde); chk("a.vblank", a_vb, e.vb);
    chk("a.frame_start", a_fs, e.fs); chk("a.Hs", a_hs, e.hs);
    chk("a.Vs", a_vs, e.vs); chk("a.de", a_de, e.de);
    chk("a.rgb", {a_r, a_g, a_b}, e.rgb);
    e = model(CB, n, en && rst);
    chk("b.col", b_col, e.col);  chk("b.row", b_row, e.row);
    chk("b.fetch_de", b_fde, e.fde); chk("b.vblank", b_vb, e.vb);
    chk("b.frame_start", b_fs, e.fs); chk("b.Hs", b_hs, e.hs);
    chk("b.Vs", b_vs, e.vs); chk("b.de", b_de, e.de);
    chk("b.rgb", {b_r, b_g, b_b}, e.rgb);
    e = model(CC, n, en && rst);
    chk("c.col", c_col, e.col);  chk("c.row", c_row, e.row);
    chk("c.fetch_de", c_fde, e.fde); chk("c.vblank", c_vb, e.vb);
    chk("c.frame_start", c_fs, e.fs); chk("c.Hs", c_hs, e.hs);
    chk("c.Vs", c_vs, e.vs); chk("c.de", c_de, e.de);
    chk("c.rgb", {c_r, c_g, c_b}, e.rgb);
  endtask

  task automatic drive_pix();
    a_pix = 9'(src_pix(CA, n));
    b_pix = 6'(src_pix(CB, n));
    c_pix = 12'(src_pix(CC, n));
  endtask

  task automatic step(bit en_next);
    @(posedge clk);
    if (en && rst) n++;
    #1;
    en = en_next;
    drive_pix();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    en  = 1'b0;
    n   = 0;
    drive_pix();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    drive_pix();
    #1;
    check_all();
  endtask

  vec_t tbl[15];

  initial begin
    // n, col, row, Hs, Vs, de, frame_start, vblank for dut_a with en held high
    tbl[0]  = '{0,   0,  0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1,   1,  0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{2,   2,  0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{3,   3,  0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{10, 10,  0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{11, 11,  0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{13, 13,  0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{15, 15,  0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{16,  0,  1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{80,  0,  5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{83,  3,  5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{99,  3,  6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{115, 3,  7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{128, 0,  0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{131, 3,  0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    a_pix = '0;
    b_pix = '0;
    c_pix = '0;
    do_reset();

    foreach (tbl[i]) begin
      while (n < tbl[i].n) step(1'b1);
      chk("vec.col", a_col, tbl[i].col);
      chk("vec.row", a_row, tbl[i].row);
      chk("vec.Hs", a_hs, tbl[i].hs);
      chk("vec.Vs", a_vs, tbl[i].vs);
      chk("vec.de", a_de, tbl[i].de);
      chk("vec.frame_start", a_fs, tbl[i].fs);
      chk("vec.vblank", a_vb, tbl[i].vb);
    end

    // Enable toggling every other clock: outputs must hold in disabled cycles.
    for (int i = 0; i < 400; i++) step(i[0]);

    for (int i = 0; i < 12000; i++) step($urandom_range(3) != 0);

    // Asynchronous reset mid-cycle: reset values must appear before the next edge.
    rst = 1'b0;
    n   = 0;
    #1;
    chk("arst.col", a_col, 0);
    chk("arst.row", a_row, 0);
    chk("arst.Hs", a_hs, 1);
    chk("arst.Vs", a_vs, 1);
    chk("arst.de", a_de, 0);
    chk("arst.rgb", {a_r, a_g, a_b}, 0);
    chk("arst.frame_start", a_fs, 0);
    chk("arst.b_Hs", b_hs, 0);
    chk("arst.b_Vs", b_vs, 0);
    chk("arst.c_col", c_col, 0);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    drive_pix();
    #1;
    chk("rel.frame_start", a_fs, 1);
    check_all();

    for (int i = 0; i < 8000; i++) step($urandom_range(3) != 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA scanner.
- Generates horizontal and vertical counters and sync pulses from configurable timing parameters, with selectable sync polarity.
- Issues a pixel fetch coordinate, and delays sync and blanking by a configurable pipeline depth so they align with pixel data returned by the framebuffer/char-ROM path.
- Sits between the pixel source (VRAM reader) and the board DAC pins; the blanking it produces zeroes RGB.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HS_POL, 0, asserted level of Hs (0 = active-low)
- VS_POL, 0, asserted level of Vs
- COLOR_W, 3, bits per colour channel
- PIPE, 2, pixel source latency in clocks (0..4)
- CNT_W, 11, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  pixel clock (25 MHz for defaults)
- rst  in  1  asynchronous active-low reset
- en  in  1  count enable; when 0 all counters and pipelines hold
- pix_in  in  3*COLOR_W  {R,G,B} from pixel source, valid PIPE clocks after col/row
- col  out  CNT_W  current horizontal count (fetch address)
- row  out  CNT_W  current vertical count
- fetch_de  out  1  col<H_ACTIVE && row<V_ACTIVE (undelayed)
- R, G, B  out  COLOR_W each  registered colour output, zero when blanked
- Hs  out  1  horizontal sync, delayed PIPE+1 clocks
- Vs  out  1  vertical sync, delayed PIPE+1 clocks
- de  out  1  display-enable aligned with RGB
- frame_start  out  1  one-clock pulse when col==0 && row==0 (undelayed)
- vblank  out  1  row>=V_ACTIVE (undelayed), for CPU/VRAM arbitration

Behaviour:
- Reset (rst=0, async): col=0, row=0, delay pipelines cleared, R=G=B=0, de=0, Hs=~HS_POL, Vs=~VS_POL, frame_start=0.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = sum of the V parameters. Defaults give 800 and 525.
- Counters update on the rising edge of clk when en=1:
  - col==H_TOTAL-1 gives col=0.
  - At that wrap, row increments, or row==V_TOTAL-1 gives row=0.
  - Otherwise col increments.
- Raw horizontal sync is asserted for col in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; defaults give 656..751.
- Raw vertical sync is asserted for row in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]; defaults give 490..491.
- Raw de is fetch_de.
- Raw hsync, vsync and de pass through a PIPE-stage shift register, then one output register. Hs, Vs, de and RGB therefore all change PIPE+1 clocks after the col/row that produced them.
- Output register:
  - RGB = pix_in when the delayed de is 1.
  - RGB = 0 otherwise.
  - Hs = delayed hsync ? HS_POL : ~HS_POL; Vs likewise.
- en=0 freezes counters, shift registers and outputs. No pulse is lost or duplicated; frame_start is held low while en=0.
- frame_start, fetch_de and vblank are combinational from the counters; they are not delayed.
- If rst is asserted mid-line, everything returns to reset values immediately. After release, the first frame begins at col=0,row=0, with frame_start high in the first cycle where en=1.
- Parameter legality (elaboration-time check, $error): every parameter >0 except PIPE; 2^CNT_W > H_TOTAL and V_TOTAL.

Decomposition:
- Package vga_pkg holds:
  - the default 640x480@60 timing constants, plus an 800x600@72 set (H 800/56/120/64, V 600/37/6/23);
  - the RGB struct width helper;
  - a function computing the total for a timing set.
- One natural sub-module, vga_delay_line (WIDTH, DEPTH), is a reset-able enable-gated shift register. It is used for the {hsync, vsync, de} bundle; DEPTH=0 degenerates to a wire.

Test Plan:
- Reset then run 2 frames at defaults, en=1 → col wraps 799→0; row wraps 524→0; frame_start pulses every 420000 clocks; Hs low exactly 96 clocks per line starting 3 clocks after col=656 (PIPE=2); Vs low for 2 lines starting at row 490 (delayed 3 clocks).
- pix_in driven = col[8:0] delayed by 2 clocks (model of 2-cycle RAM), PIPE=2 → on every de=1 cycle, {R,G,B} equals the col value issued 3 clocks earlier; RGB=0 for all 160 blank clocks per line and all rows ≥480.
- HS_POL=1, VS_POL=1 → Hs/Vs idle low, pulse high over the same windows; reset value Hs=0, Vs=0.
- en toggled 1/0 every other clock for 1 line → line takes 1600 clocks; Hs pulse width 192 clocks; no output changes in en=0 cycles.
- Assert rst at col=300,row=200 for 1 clock, asynchronously mid-cycle → outputs go to reset values before the next edge; after release, col=0,row=0 and frame_start=1.
- 800x600 parameter set, CNT_W=11 → H_TOTAL=1040, V_TOTAL=666; Hs asserted for col 856..975; vblank=1 for rows 600..665.
